fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, address of first fetched instruction after reset.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: imem_req  output  1  instruction-memory request, held high until imem_ack.
REQ-005: imem_addr  output  32  fetch address, equal to PC while imem_req=1.
REQ-006: imem_ack  input  1  one-cycle completion strobe; imem_rdata valid in the same cycle.
REQ-007: imem_rdata  input  32  instruction word returned by memory.
REQ-008: stall  input  1  decode cannot accept; IF/ID register holds.
REQ-009: branch_taken  input  1  one-cycle redirect pulse from the branch/beq resolution stage.
REQ-010: branch_target  input  32  redirect address; bits [1:0] forced to 0 on capture.
REQ-011: if_id_instr  output  32  registered instruction presented to decode.
REQ-012: if_id_pc4  output  32  registered address of that instruction plus 4.
REQ-013: if_id_valid  output  1  if_id_instr holds a real instruction (0 = bubble).
REQ-014: OPCODE  output  6  if_id_instr[31:26], combinational, drives unit_control directly.

Function
REQ-015: FSM states IDLE, REQ, HOLD; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-016: REQ: imem_req=1, imem_addr=PC, stable until the ack cycle.
REQ-017: REQ, imem_ack=1, stall=0: if_id_instr<=imem_rdata, if_id_pc4<=PC+4, if_id_valid<=1, PC<=PC+4, remain REQ (back-to-back fetches, one per ack).
REQ-018: REQ, imem_ack=1, stall=1: imem_rdata captured into a one-entry skid register, PC<=PC+4, go HOLD; IF/ID unchanged.
REQ-019: HOLD: imem_req=0; when stall=0, IF/ID loads the skid contents with valid=1, then REQ next cycle.
REQ-020: stall=1 in any state: if_id_instr, if_id_pc4 and if_id_valid hold their values.
REQ-021: stall=0 with no new instruction available: if_id_valid<=0 and if_id_instr<=32'h0 (NOP); if_id_pc4 holds.
REQ-022: branch_taken has priority over stall and ack: PC<=branch_target, IF/ID cleared (valid=0, instr=0), skid discarded.
REQ-023: branch_taken in REQ with ack in the same cycle: returned word dropped; the next cycle requests branch_target.
REQ-024: branch_taken in REQ with no ack: kill flag set, imem_req stays high with the old address until ack, that ack's data dropped, kill cleared, then branch_target requested.
REQ-025: branch_taken in HOLD or IDLE: go REQ on branch_target (IDLE still waits out its single cycle).
REQ-026: PC arithmetic modulo 2^32: PC=32'hFFFF_FFFC plus 4 gives 32'h0000_0000, if_id_pc4 likewise.
REQ-027: PC[1:0] is always 2'b00.

Reset
REQ-028: rst_n=0 immediately sets PC=RESET_PC, state=IDLE, kill=0, skid empty, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, OPCODE=0.
REQ-029: Reset asserted mid-request abandons it; any imem_ack during reset is ignored.
REQ-030: After reset release, the first imem_req is asserted on the second rising edge, with imem_addr=RESET_PC.

Verification
REQ-031: Reset release, ack every cycle -> imem_addr 0,4,8,...; if_id_pc4 4,8,12; valid=1 from the first ack's next edge.
REQ-032: Ack with stall=1, hold stall 3 cycles -> IF/ID unchanged, imem_req=0 during HOLD, skid word appears one edge after stall drops, no instruction lost or duplicated.
REQ-033: branch_taken with target 0x0000_0103 while ack in the same cycle -> word dropped, next imem_addr=0x0000_0100, if_id_valid=0.
REQ-034: branch_taken during outstanding request, ack 2 cycles later -> that data dropped, next request to target, IF/ID never shows the dropped word.
REQ-035: RESET_PC=32'hFFFF_FFFC, one ack -> if_id_pc4=0, next imem_addr=0.
REQ-036: lw opcode 6'b100011 fetched with stall=0 -> OPCODE=6'b100011 and if_id_valid=1 on the following cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, single outstanding instruction-memory
// request, one-entry skid buffer for stalls, and branch redirect with kill of in-flight data.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  OPCODE
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] br_tgt;
  logic [31:0] pc_inc;
  logic        load_new;
  logic [31:0] new_instr;
  logic [31:0] new_pc4;

  assign br_tgt = {branch_target[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (!branch_taken && imem_ack && !kill_q && stall) state_d = HOLD;
      HOLD:    if (branch_taken || !stall) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = pc_q;
  end

  // While a kill is pending the PC keeps the in-flight address; the redirect waits in tgt_q.
  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    kill_d    = kill_q;
    skid_d    = skid_q;
    load_new  = 1'b0;
    new_instr = 32'h0;
    new_pc4   = pc4_q;
    case (state_q)
      IDLE: begin
        if (branch_taken) pc_d = br_tgt;
      end
      REQ: begin
        if (branch_taken) begin
          if (imem_ack) begin
            pc_d   = br_tgt;
            kill_d = 1'b0;
          end else begin
            tgt_d  = br_tgt;
            kill_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill_q) begin
            pc_d   = tgt_q;
            kill_d = 1'b0;
          end else if (stall) begin
            skid_d = imem_rdata;
            pc_d   = pc_inc;
          end else begin
            load_new  = 1'b1;
            new_instr = imem_rdata;
            new_pc4   = pc_inc;
            pc_d      = pc_inc;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d = br_tgt;
        end else if (!stall) begin
          // PC already advanced past the skid word, so it is that word's pc4.
          load_new  = 1'b1;
          new_instr = skid_q;
          new_pc4   = pc_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (branch_taken) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (load_new) begin
        instr_d = new_instr;
        pc4_d   = new_pc4;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      kill_q  <= 1'b0;
      skid_q  <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign OPCODE      = instr_q[31:26];

endmodule
